seg7_frame_sched: RTL and testbench

- Schedules and sequences frames for the board's serial seven-segment shift chain (SEGLED_CLK/DO/PEN/CLR).
- Arbitrates between two 64-bit pattern producers, for example the game score path and the debug/status path.
- Shifts the winning pattern out MSB-first at a divided bit rate, then strobes the display enable.
- Replaces the free-running shifter with a handshaked, one-frame-at-a-time controller.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_rr_arb2.sv | 23 ++
 rtl/seg7_frame_sched.sv | 152 +++++++++++++++
 tb/tb_seg7_frame_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the serial seven-segment frame scheduler.
package seg7_pkg;

  localparam int SEG7_FRAME_W   = 64;
  localparam int SEG7_BIT_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } seg7_state_e;

endpackage

// File: rtl/seg7_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid wins, contention goes to the
// requester that was not granted last.
module seg7_rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // NOTE: assigning a default first keeps this combinational block free of latches.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid0 && (!valid1 || last_grant)) begin
        grant = 2'b01;
      end else if (valid1) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/seg7_frame_sched.sv
// Accepts one 64-bit frame at a time from two requesters and shifts it
// MSB-first onto the SEGLED chain, then strobes the latch enable.
module seg7_frame_sched
  import seg7_pkg::*;
#(
  parameter int DIV       = 8,
  parameter int LATCH_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  input  logic [SEG7_FRAME_W-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [SEG7_FRAME_W-1:0] req1_data,
  output logic                    req1_ready,
  output logic                    busy,
  output logic                    last_grant,
  output logic                    SEGLED_CLK,
  output logic                    SEGLED_DO,
  output logic                    SEGLED_PEN,
  output logic                    SEGLED_CLR
);

  localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
  localparam logic [7:0] LATCH_M1 = 8'(LATCH_CYC - 1);

  seg7_state_e               state_q, state_d;
  logic [SEG7_FRAME_W-1:0]   sr_q, sr_d;
  logic [SEG7_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]                phase_q, phase_d;
  logic                      last_grant_q, last_grant_d;
  logic                      busy_q, busy_d;
  logic                      sclk_q, sclk_d;
  logic                      do_q, do_d;
  logic                      pen_q, pen_d;
  logic                      clr_q, clr_d;
  logic [1:0]                grant;

  seg7_rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .enable     (state_q == ST_IDLE),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    phase_d      = phase_q;
    last_grant_d = last_grant_q;
    sclk_d       = sclk_q;
    do_d         = do_q;
    pen_d        = pen_q;
    clr_d        = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        pen_d = 1'b1;
        if (|grant) begin
          last_grant_d = grant[1];
          sr_d         = grant[1] ? req1_data : req0_data;
          bit_cnt_d    = '1;
          pen_d        = 1'b0;
          do_d         = sr_d[SEG7_FRAME_W-1];
          sclk_d       = 1'b0;
          phase_d      = DIV_M1;
          state_d      = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_q == 8'd0) begin
          sclk_d  = 1'b1;
          phase_d = DIV_M1;
          state_d = ST_SHIFT_HI;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_q == 8'd0) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != '0) begin
            // Rotate rather than shift: the bit leaving the top is already on DO.
            sr_d      = {sr_q[SEG7_FRAME_W-2:0], sr_q[SEG7_FRAME_W-1]};
            do_d      = sr_q[SEG7_FRAME_W-2];
            bit_cnt_d = bit_cnt_q - 1'b1;
            phase_d   = DIV_M1;
            state_d   = ST_SHIFT_LO;
          end else begin
            do_d    = 1'b0;
            phase_d = LATCH_M1;
            state_d = ST_LATCH;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      ST_LATCH: begin
        if (phase_q == 8'd0) begin
          pen_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      phase_q      <= '0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      sclk_q       <= 1'b0;
      do_q         <= 1'b0;
      pen_q        <= 1'b0;
      clr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      phase_q      <= phase_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      sclk_q       <= sclk_d;
      do_q         <= do_d;
      pen_q        <= pen_d;
      clr_q        <= clr_d;
    end
  end

  assign busy       = busy_q;
  assign last_grant = last_grant_q;
  assign SEGLED_CLK = sclk_q;
  assign SEGLED_DO  = do_q;
  assign SEGLED_PEN = pen_q;
  assign SEGLED_CLR = clr_q;

endmodule

// File: tb/tb_seg7_frame_sched.sv
// Randomized bench for seg7_frame_sched: a chain monitor rebuilds each frame
// from SEGLED pins and compares it with a round-robin reference model.
module tb_seg7_frame_sched;

  localparam int DIV       = 2;
  localparam int LATCH_CYC = 4;
  localparam int FRAME_CYC = 128 * DIV + LATCH_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, busy, last_grant;
  logic        SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR;

  always #5 clk = ~clk;

  seg7_frame_sched #(.DIV(DIV), .LATCH_CYC(LATCH_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .busy       (busy),
    .last_grant (last_grant),
    .SEGLED_CLK (SEGLED_CLK),
    .SEGLED_DO  (SEGLED_DO),
    .SEGLED_PEN (SEGLED_PEN),
    .SEGLED_CLR (SEGLED_CLR)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Chain monitor: what a real shift chain would have captured.
  bit          mon_en = 1'b0;
  logic [63:0] mon_bits;
  int          mon_rises, mon_pen_low, mon_setup_err, do_age;
  logic        prev_clk, prev_do;

  always @(negedge clk) begin
    if (mon_en) begin
      if (SEGLED_CLK && !prev_clk) begin
        mon_bits = {mon_bits[62:0], SEGLED_DO};
        mon_rises++;
        if (do_age < DIV) mon_setup_err++;
      end
      if (SEGLED_DO !== prev_do) do_age = 1;
      else do_age++;
      if (!SEGLED_PEN) mon_pen_low++;
      prev_clk = SEGLED_CLK;
      prev_do  = SEGLED_DO;
    end
  end

  task automatic mon_start();
    mon_bits      = '0;
    mon_rises     = 0;
    mon_pen_low   = 0;
    mon_setup_err = 0;
    do_age        = 0;
    prev_clk      = SEGLED_CLK;
    prev_do       = SEGLED_DO;
    mon_en        = 1'b1;
  endtask

  logic m_lg = 1'b1;

  // One full frame: present requests, check grant, follow the frame to IDLE.
  task automatic do_frame(input logic v0, input logic v1, input logic [63:0] d0,
                          input logic [63:0] d1, input bit scramble, input bit hold1);
    logic        winner;
    logic [63:0] exp_data;
    int          n, leak;
    @(posedge clk); #1;
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    winner   = (v0 && v1) ? ~m_lg : v1;
    exp_data = winner ? d1 : d0;
    @(negedge clk);
    check("idle_before_accept", busy, 1'b0);
    check("ready0", req0_ready, winner == 1'b0);
    check("ready1", req1_ready, winner == 1'b1);
    @(posedge clk);
    m_lg = winner;
    #1;
    req0_valid = 1'b0;
    req1_valid = hold1;
    mon_start();
    n = 0; leak = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (req0_ready || req1_ready) leak++;
      if (scramble) begin
        req0_data = {$urandom, $urandom};
        req1_data = {$urandom, $urandom};
      end
      if (n > FRAME_CYC + 50) begin
        check("busy_timeout", 1'b1, 1'b0);
        break;
      end
    end
    mon_en = 1'b0;
    check("last_grant", last_grant, winner);
    check("busy_len", n, FRAME_CYC);
    check("clk_rises", mon_rises, 64);
    check("bit_stream", mon_bits, exp_data);
    check("pen_low_len", mon_pen_low, FRAME_CYC);
    check("do_setup", mon_setup_err, 0);
    check("ready_during_frame", leak, 0);
    check("do_idle", SEGLED_DO, 1'b0);
    check("pen_idle", SEGLED_PEN, 1'b1);
    if (hold1) begin
      check("hold_ready1_first_idle", req1_ready, 1'b1);
      req1_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_clk", SEGLED_CLK, 1'b0);
    check("rst_do", SEGLED_DO, 1'b0);
    check("rst_pen", SEGLED_PEN, 1'b0);
    check("rst_clr", SEGLED_CLR, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_last_grant", last_grant, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_clr", SEGLED_CLR, 1'b1);
    check("post_rst_pen", SEGLED_PEN, 1'b1);
    check("idle_ready0", req0_ready, 1'b0);
    check("idle_ready1", req1_ready, 1'b0);

    // Contention alternates: req0, req1, req0.
    for (int i = 0; i < 3; i++)
      do_frame(1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0);

    do_frame(1'b1, 1'b0, 64'h8000_0000_0000_0001, 64'h0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, {$urandom, $urandom}, 64'h0, 1'b0, 1'b1);
    do_frame(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);

    // Reset in the middle of bit 30.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = {$urandom, $urandom};
    @(posedge clk); #1;
    req0_valid = 1'b0;
    mon_start();
    n = 0;
    while (mon_rises < 34 && n < 1000) begin
      @(posedge clk); n++;
    end
    check("reached_bit30", mon_rises >= 34, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mon_en = 1'b0;
    m_lg   = 1'b1;
    check("midrst_clk", SEGLED_CLK, 1'b0);
    check("midrst_do", SEGLED_DO, 1'b0);
    check("midrst_pen", SEGLED_PEN, 1'b0);
    check("midrst_clr", SEGLED_CLR, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_last_grant", last_grant, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_clr", SEGLED_CLR, 1'b1);
    check("midrst_release_pen", SEGLED_PEN, 1'b1);
    do_frame(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      do_frame(v[0], v[1], {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
